// File: rtl/storage_pkg.sv
// Shared constants for the storage-element library (latch banks and cells).
// Width limits and the per-bit reset value used by every cell.
package storage_pkg;

    localparam int   DLATCH_DEFAULT_WIDTH = 32;
    localparam int   DLATCH_MAX_WIDTH     = 1024;
    localparam logic DLATCH_RESET_VAL     = 1'b0;

    function automatic bit dlatch_width_ok(input int width);
        return (width >= 1) && (width <= DLATCH_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/d_latch_cell.sv
// One-bit clocked latch emulation: hold flop with async active-low clear plus enable mux.
// Latency: d->q combinational while en=1, capture on rising clk; no backpressure.
module d_latch_cell
    import storage_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);

    logic r_held;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_held <= DLATCH_RESET_VAL;
        end else if (en) begin
            r_held <= d;
        end
    end

    // Reset gates the transparent path too, so q is cleared even with en=1.
    assign q = !reset ? DLATCH_RESET_VAL : (en ? d : r_held);

endmodule

// File: rtl/d_latch.sv
// WIDTH-bit latch bank with complementary outputs; q_par exists only with DLATCH_PARITY_EN.
// Latency: d->q/qbar combinational while en=1, held from each rising edge with en=1; no backpressure.
module d_latch
    import storage_pkg::*;
#(
    parameter int WIDTH = DLATCH_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
`ifdef DLATCH_PARITY_EN
    ,
    output logic             q_par
`endif
);

    if (!dlatch_width_ok(WIDTH)) begin : g_bad_width
        $fatal(1, "d_latch: WIDTH=%0d outside 1..%0d", WIDTH, DLATCH_MAX_WIDTH);
    end

    logic [WIDTH-1:0] w_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        d_latch_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .d     (d[i]),
            .q     (w_q[i])
        );
    end

    assign q    = w_q;
    assign qbar = ~w_q;

`ifdef DLATCH_PARITY_EN
    // w_q is already zero in reset, so parity reads 0 there without extra gating.
    assign q_par = ^w_q;
`endif

endmodule

// File: tb/tb_d_latch.sv
// Bench for d_latch at WIDTH=32: directed vector table, hand corner sequences, random vs model.
module tb_d_latch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b1;
    logic [31:0] d = 32'hFFFF_FFFF;
    logic [31:0] q;
    logic [31:0] qbar;
`ifdef DLATCH_PARITY_EN
    logic        q_par;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] m_held = 32'h0;

    d_latch #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (d),
        .q     (q),
        .qbar  (qbar)
`ifdef DLATCH_PARITY_EN
        ,
        .q_par (q_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] d;
        logic [31:0] exp_q;
        string       name;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [31:0] exp_q);
        chk({name, ".q"}, q, exp_q);
        chk({name, ".qbar"}, qbar, ~exp_q);
`ifdef DLATCH_PARITY_EN
        chk({name, ".q_par"}, {31'h0, q_par}, {31'h0, ^exp_q});
`endif
    endtask

    // The model captures whatever the bank saw at the edge, then inputs move 1ns later.
    task automatic drive(input logic r, input logic e, input logic [31:0] dv);
        @(posedge clk);
        if (reset && en) m_held = d;
        #1;
        reset = r;
        en    = e;
        d     = dv;
        if (!r) m_held = 32'h0;
    endtask

    function automatic logic [31:0] model_q();
        if (!reset) return 32'h0;
        return en ? d : m_held;
    endfunction

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, "rst_en1_a"};
        vecs[1]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, "rst_en1_b"};
        vecs[2]  = '{1'b1, 1'b1, 32'hA5A5_0F0F, 32'hA5A5_0F0F, "transp_a5"};
        vecs[3]  = '{1'b1, 1'b0, 32'h1234_5678, 32'hA5A5_0F0F, "hold_1"};
        vecs[4]  = '{1'b1, 1'b0, 32'h1234_5678, 32'hA5A5_0F0F, "hold_2"};
        vecs[5]  = '{1'b1, 1'b0, 32'h1234_5678, 32'hA5A5_0F0F, "hold_3"};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0001, 32'h0000_0001, "transp_1"};
        vecs[7]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, "fall_hold_1"};
        vecs[8]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "transp_dead"};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, "hold_dead"};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, "rst_mid_hold"};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, "rel_en0"};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0055, 32'h0000_0000, "rel_en0_hold"};

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].d);
            @(negedge clk);
            chk_out(vecs[i].name, vecs[i].exp_q);
        end

        // d moves between edges while transparent: q follows without an edge.
        drive(1'b1, 1'b1, 32'h0F0F_0F0F);
        @(negedge clk);
        #1 d = 32'h3C3C_3C3C;
        #1 chk_out("midcycle_d", 32'h3C3C_3C3C);
        drive(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk_out("hold_midcycle_d", 32'h3C3C_3C3C);

        // Reset asserted between edges clears q at once and discards the held value.
        #1 begin reset = 1'b0; m_held = 32'h0; end
        #1 chk_out("async_rst", 32'h0);
        drive(1'b1, 1'b0, 32'h7777_7777);
        @(negedge clk);
        chk_out("after_async_rst", 32'h0);

        // en rising between edges switches q to d immediately.
        #1 en = 1'b1;
        #1 chk_out("en_rise", 32'h7777_7777);
        drive(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk_out("en_rise_hold", 32'h7777_7777);

`ifdef DLATCH_PARITY_EN
        drive(1'b1, 1'b1, 32'h0000_0007);
        @(negedge clk);
        chk("par_7", {31'h0, q_par}, 32'h1);
        drive(1'b1, 1'b1, 32'h0000_0003);
        @(negedge clk);
        chk("par_3", {31'h0, q_par}, 32'h0);
`endif

        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        e;
            logic [31:0] dv;
            r  = ($urandom_range(0, 15) != 0);
            e  = 1'($urandom_range(0, 1));
            dv = ($urandom_range(0, 3) == 0) ? d : $urandom;
            drive(r, e, dv);
            @(negedge clk);
            chk_out("rand", model_q());
            if (reset && en && $urandom_range(0, 3) == 0) begin
                #1 d = $urandom;
                #1 chk_out("rand_mid", model_q());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
